// File: rtl/studio2_pkg.sv
// Shared types and constants for the Studio II single-port memory arbiter.
package studio2_pkg;

    localparam int ADDR_W = 12;

    localparam logic [ADDR_W-1:0] ROM_BASE  = 12'h000;
    localparam logic [ADDR_W-1:0] CART_BASE = 12'h400;
    localparam int                ROM_SIZE  = 1024;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_DMA,
        REQ_CPU,
        REQ_IOCTL
    } req_id_e;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_ACTIVE,
        LD_DRAIN
    } load_state_e;

endpackage

// File: rtl/studio2_ioctl_buffer.sv
// Loader side of the arbiter: index/range filter, one-entry write buffer,
// buffer age counter for starvation control and saturating drop counter.
module studio2_ioctl_buffer
    import studio2_pkg::*;
#(
    parameter logic [7:0] ROM_INDEX  = 8'h00,
    parameter logic [7:0] CART_INDEX = 8'h01,
    parameter int         CART_SIZE  = 3072,
    parameter int         STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_index,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              commit_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        data_o,
    output logic              starved_o,
    output logic [7:0]        drop_count_o
);

    localparam int AGE_W = $clog2(STARVE_MAX + 2);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [AGE_W-1:0]  age_q, age_d;
    logic [7:0]        drop_q, drop_d;
    logic              in_range;
    logic [ADDR_W-1:0] base;
    logic              accept;
    logic              drop;

    always_comb begin
        in_range = 1'b0;
        base     = ROM_BASE;
        if (ioctl_index == ROM_INDEX) begin
            in_range = (ioctl_addr < 25'(ROM_SIZE));
            base     = ROM_BASE;
        end else if (ioctl_index == CART_INDEX) begin
            in_range = (ioctl_addr < 25'(CART_SIZE));
            base     = CART_BASE;
        end
    end

    // A write arriving while the buffer is still full is a loader protocol error.
    assign accept    = ioctl_wr && in_range && !valid_q;
    assign drop      = ioctl_wr && !accept;
    assign starved_o = valid_q && (age_q >= AGE_W'(STARVE_MAX));

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        age_d   = age_q;
        drop_d  = drop_q;
        if (commit_i) begin
            valid_d = 1'b0;
            age_d   = '0;
        end else if (valid_q && !starved_o) begin
            age_d = age_q + 1'b1;
        end
        if (accept) begin
            valid_d = 1'b1;
            addr_d  = base + ioctl_addr[ADDR_W-1:0];
            data_d  = ioctl_dout;
            age_d   = '0;
        end
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            age_q   <= '0;
            drop_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            age_q   <= age_d;
            drop_q  <= drop_d;
        end
    end

    assign valid_o      = valid_q;
    assign addr_o       = addr_q;
    assign data_o       = data_q;
    assign drop_count_o = drop_q;

endmodule

// File: rtl/studio2_mem_arbiter.sv
// Single-port RAM arbiter for the Studio II core (video DMA, CPU, ioctl loader).
// Optional STUDIO2_ARB_WRPROT_EN blocks CPU writes below 12'h800 (still acked).
module studio2_mem_arbiter
    import studio2_pkg::*;
#(
    parameter logic [7:0] ROM_INDEX  = 8'h00,
    parameter logic [7:0] CART_INDEX = 8'h01,
    parameter int         CART_SIZE  = 3072,
    parameter int         STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_index,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic              dma_ack,
    output logic [7:0]        dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              load_done,
    output logic [7:0]        drop_count
);

    logic              buf_valid, buf_starved;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;
    req_id_e           grant, tag1_q, tag2_q;
    load_state_e       ld_q, ld_d;
    logic              load_done_q, load_done_d;
    logic              cpu_lockout, dma_busy, cpu_busy, cpu_wr_en;
    logic              dma_ok, cpu_ok, io_ok;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    studio2_ioctl_buffer #(
        .ROM_INDEX  (ROM_INDEX),
        .CART_INDEX (CART_INDEX),
        .CART_SIZE  (CART_SIZE),
        .STARVE_MAX (STARVE_MAX)
    ) u_buffer (
        .clk          (clk),
        .reset_n      (reset_n),
        .ioctl_wr     (ioctl_wr),
        .ioctl_index  (ioctl_index),
        .ioctl_addr   (ioctl_addr),
        .ioctl_dout   (ioctl_dout),
        .commit_i     (grant == REQ_IOCTL),
        .valid_o      (buf_valid),
        .addr_o       (buf_addr),
        .data_o       (buf_data),
        .starved_o    (buf_starved),
        .drop_count_o (drop_count)
    );

`ifdef STUDIO2_ARB_WRPROT_EN
    localparam logic [ADDR_W-1:0] WRPROT_LIMIT = 12'h800;
    assign cpu_wr_en = cpu_we && (cpu_addr >= WRPROT_LIMIT);
`else
    assign cpu_wr_en = cpu_we;
`endif

    // The CPU stays locked out through the load_done pulse so it never sees a partial image.
    assign cpu_lockout = ioctl_download || (ld_q != LD_IDLE) || load_done_q;
    assign dma_busy    = (tag1_q == REQ_DMA) || (tag2_q == REQ_DMA);
    assign cpu_busy    = (tag1_q == REQ_CPU) || (tag2_q == REQ_CPU);
    assign dma_ok      = dma_req && !dma_busy;
    assign cpu_ok      = cpu_req && !cpu_busy && !cpu_lockout;
    assign io_ok       = buf_valid;

    always_comb begin
        grant = REQ_NONE;
        if (dma_ok) begin
            grant = REQ_DMA;
        end else if (buf_starved && io_ok) begin
            grant = REQ_IOCTL;
        end else if (cpu_ok) begin
            grant = REQ_CPU;
        end else if (io_ok) begin
            grant = REQ_IOCTL;
        end
    end

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        case (grant)
            REQ_DMA: begin
                mem_addr_d = dma_addr;
            end
            REQ_CPU: begin
                mem_addr_d  = cpu_addr;
                mem_we_d    = cpu_wr_en;
                mem_wdata_d = cpu_wdata;
            end
            REQ_IOCTL: begin
                mem_addr_d  = buf_addr;
                mem_we_d    = 1'b1;
                mem_wdata_d = buf_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_d        = ld_q;
        load_done_d = 1'b0;
        case (ld_q)
            LD_IDLE:   if (ioctl_download) ld_d = LD_ACTIVE;
            LD_ACTIVE: if (!ioctl_download) ld_d = LD_DRAIN;
            LD_DRAIN: begin
                if (!buf_valid) begin
                    load_done_d = 1'b1;
                    ld_d        = LD_IDLE;
                end
            end
            default:   ld_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            tag1_q      <= REQ_NONE;
            tag2_q      <= REQ_NONE;
            ld_q        <= LD_IDLE;
            load_done_q <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            tag1_q      <= grant;
            tag2_q      <= tag1_q;
            ld_q        <= ld_d;
            load_done_q <= load_done_d;
        end
    end

    // The second tag stage lines up with the RAM's registered read data.
    assign cpu_ack    = (tag2_q == REQ_CPU);
    assign dma_ack    = (tag2_q == REQ_DMA);
    assign cpu_rdata  = cpu_ack ? mem_rdata : 8'h00;
    assign dma_rdata  = dma_ack ? mem_rdata : 8'h00;
    assign ioctl_wait = buf_valid;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign load_done  = load_done_q;

endmodule

// File: tb/tb_studio2_mem_arbiter.sv
// Randomized bench for studio2_mem_arbiter with a behavioural RAM and reference image.
module tb_studio2_mem_arbiter;

    localparam logic [7:0] ROM_INDEX  = 8'h00;
    localparam logic [7:0] CART_INDEX = 8'h01;
    localparam int         CART_SIZE  = 3072;
    localparam int         STARVE_MAX = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_download, ioctl_wr, ioctl_wait;
    logic [7:0]  ioctl_index, ioctl_dout;
    logic [24:0] ioctl_addr;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        dma_req, dma_ack;
    logic [11:0] dma_addr;
    logic [7:0]  dma_rdata;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        load_done;
    logic [7:0]  drop_count;

    logic [7:0]  ram    [0:4095];
    logic [7:0]  refMem [0:4095];
    int checks = 0;
    int errors = 0;
    int expDrop = 0;
    int cycle = 0;
    int weCount = 0;
    int lastWeCycle = 0;
    int loadDoneCount = 0;
    int loadDoneCycle = 0;

    studio2_mem_arbiter #(
        .ROM_INDEX  (ROM_INDEX),
        .CART_INDEX (CART_INDEX),
        .CART_SIZE  (CART_SIZE),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_ack        (cpu_ack),
        .cpu_rdata      (cpu_rdata),
        .dma_req        (dma_req),
        .dma_addr       (dma_addr),
        .dma_ack        (dma_ack),
        .dma_rdata      (dma_rdata),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .load_done      (load_done),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
        cycle <= cycle + 1;
    end

    always @(negedge clk) begin
        if (mem_we) begin
            weCount++;
            lastWeCycle = cycle;
        end
        if (load_done) begin
            loadDoneCount++;
            loadDoneCycle = cycle;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit cpuWritable(input logic [11:0] a);
`ifdef STUDIO2_ARB_WRPROT_EN
        return a >= 12'h800;
`else
        return 1'b1;
`endif
    endfunction

    // One DMA and/or CPU transaction; requests held until their ack.
    task automatic applyStimulus(input bit doDma, input bit doCpu, input bit cpuWe,
                                 input logic [11:0] dAddr, input logic [11:0] cAddr,
                                 input logic [7:0] wdata, input int expDmaLat, input int expCpuLat);
        logic [7:0] expD, expC, gotD, gotC;
        int dLat, cLat;
        bit dPend, cPend;
        expD = refMem[dAddr];
        expC = refMem[cAddr];
        gotD = 8'h00;
        gotC = 8'h00;
        dLat = -1;
        cLat = -1;
        @(negedge clk);
        dma_req = doDma; dma_addr = dAddr;
        cpu_req = doCpu; cpu_we = cpuWe; cpu_addr = cAddr; cpu_wdata = wdata;
        dPend = doDma;
        cPend = doCpu;
        for (int i = 1; i <= 12 && (dPend || cPend); i++) begin
            @(negedge clk);
            if (dPend && dma_ack) begin
                dLat = i; gotD = dma_rdata; dma_req = 1'b0; dPend = 1'b0;
            end
            if (cPend && cpu_ack) begin
                cLat = i; gotC = cpu_rdata; cpu_req = 1'b0; cPend = 1'b0;
            end
        end
        dma_req = 1'b0;
        cpu_req = 1'b0;
        if (doDma) begin
            checkOutput("dma_latency", dLat, expDmaLat);
            checkOutput("dma_rdata", gotD, expD);
        end
        if (doCpu) begin
            checkOutput("cpu_latency", cLat, expCpuLat);
            if (!cpuWe) checkOutput("cpu_rdata", gotC, expC);
            else if (cpuWritable(cAddr)) refMem[cAddr] = wdata;
        end
    endtask

    // Full ROM download with a loader that honours ioctl_wait; CPU read of 12'h3FF held throughout.
    task automatic downloadRom();
        int sent, waitErr, earlyAck, ldBase, ackCycle, mism;
        logic [7:0] d, gotC;
        sent = 0; waitErr = 0; earlyAck = 0; ackCycle = -1; mism = 0; gotC = 8'h00;
        ldBase = loadDoneCount;
        @(negedge clk);
        ioctl_download = 1'b1; ioctl_index = ROM_INDEX;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h3FF;
        for (int k = 0; k < 4000 && sent < 1024; k++) begin
            @(negedge clk);
            if (cpu_ack) earlyAck++;
            if (ioctl_wait !== k[0]) waitErr++;
            if (!ioctl_wait) begin
                d = 8'($urandom);
                ioctl_wr = 1'b1; ioctl_addr = 25'(sent); ioctl_dout = d;
                refMem[sent] = d;
                sent++;
            end else begin
                ioctl_wr = 1'b0;
            end
        end
        @(negedge clk);
        if (cpu_ack) earlyAck++;
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        for (int i = 0; i < 20 && ackCycle < 0; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                ackCycle = cycle; gotC = cpu_rdata; cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        for (int a = 0; a < 1024; a++) if (ram[a] !== refMem[a]) mism++;
        checkOutput("rom_bytes_sent", sent, 1024);
        checkOutput("rom_wait_pattern_errs", waitErr, 0);
        checkOutput("cpu_ack_during_load", earlyAck, 0);
        checkOutput("rom_ram_mismatches", mism, 0);
        checkOutput("load_done_pulses", loadDoneCount - ldBase, 1);
        checkOutput("load_done_after_commit", loadDoneCycle > lastWeCycle, 1);
        checkOutput("cpu_ack_after_load_done", (ackCycle > loadDoneCycle), 1);
        checkOutput("rom_3ff_readback", gotC, refMem[12'h3FF]);
    endtask

    // Single ioctl write; expectation from the index/range mapping rules.
    task automatic ioctlWrite(input logic [7:0] idx, input int off, input logic [7:0] d);
        bit ok;
        logic [11:0] a;
        int we0;
        ok = 1'b0;
        a = 12'h000;
        if (idx == ROM_INDEX && off < 1024) begin
            ok = 1'b1; a = 12'(off);
        end else if (idx == CART_INDEX && off < CART_SIZE) begin
            ok = 1'b1; a = 12'h400 + 12'(off);
        end
        @(negedge clk);
        we0 = weCount;
        ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = 25'(off); ioctl_dout = d;
        @(negedge clk);
        ioctl_wr = 1'b0;
        checkOutput("ioctl_wait_after_wr", ioctl_wait, ok);
        repeat (3) @(negedge clk);
        if (ok) begin
            refMem[a] = d;
            checkOutput("ioctl_commit_data", ram[a], d);
        end else begin
            expDrop = (expDrop >= 255) ? 255 : expDrop + 1;
        end
        checkOutput("ioctl_we_count", weCount - we0, ok);
        checkOutput("drop_count", drop_count, expDrop);
    endtask

    initial begin
        int n, ackSeen, we0, mode;
        logic [11:0] dA, cA;
        logic [7:0] wd, d1, d2;
        bit we;
        for (int i = 0; i < 4096; i++) begin
            wd = 8'($urandom);
            ram[i] = wd;
            refMem[i] = wd;
        end
        reset_n = 1'b0;
        ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'h00; ioctl_addr = '0; ioctl_dout = 8'h00;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h000; cpu_wdata = 8'h00;
        dma_req = 1'b0; dma_addr = 12'h000;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs_zero", |{ioctl_wait, cpu_ack, cpu_rdata, dma_ack, dma_rdata,
                    mem_addr, mem_we, mem_wdata, load_done, drop_count}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        downloadRom();

        ioctlWrite(CART_INDEX, 3072, 8'h5A);
        ioctlWrite(CART_INDEX, 3071, 8'hC3);
        ioctlWrite(CART_INDEX, 5, 8'h77);
        ioctlWrite(ROM_INDEX, 1024, 8'h11);
        ioctlWrite(ROM_INDEX, 1023, 8'h3C);
        ioctlWrite(8'h07, 12, 8'h22);

        // Second write while the buffer is still full must be dropped.
        d1 = ~refMem[12'h010];
        d2 = ~refMem[12'h011];
        @(negedge clk);
        we0 = weCount;
        ioctl_wr = 1'b1; ioctl_index = ROM_INDEX; ioctl_addr = 25'h10; ioctl_dout = d1;
        @(negedge clk);
        ioctl_addr = 25'h11; ioctl_dout = d2;
        @(negedge clk);
        ioctl_wr = 1'b0;
        repeat (3) @(negedge clk);
        refMem[12'h010] = d1;
        expDrop++;
        checkOutput("full_first_commit", ram[12'h010], d1);
        checkOutput("full_second_dropped", ram[12'h011], refMem[12'h011]);
        checkOutput("full_we_count", weCount - we0, 1);
        checkOutput("full_drop_count", drop_count, expDrop);

        applyStimulus(1'b1, 1'b1, 1'b0, 12'h3FF, 12'h405, 8'h00, 2, 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h123, 12'h000, 8'h00, 2, 0);

        applyStimulus(1'b0, 1'b1, 1'b1, 12'h000, 12'h100, 8'hAA, 0, 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h000, 12'h100, 8'h00, 0, 2);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'h000, 12'h800, 8'h5C, 0, 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h000, 12'h800, 8'h00, 0, 2);

        // Continuous CPU traffic must not hold off a buffered loader write.
        wd = ~refMem[12'h020];
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h900;
        ioctl_wr = 1'b1; ioctl_index = ROM_INDEX; ioctl_addr = 25'h20; ioctl_dout = wd;
        refMem[12'h020] = wd;
        @(negedge clk);
        ioctl_wr = 1'b0;
        n = 1;
        while (ioctl_wait && n < 40) begin
            @(negedge clk);
            n++;
        end
        cpu_req = 1'b0;
        checkOutput("starve_bound", (n <= STARVE_MAX + 1), 1);
        repeat (4) @(negedge clk);
        checkOutput("starve_commit_data", ram[12'h020], wd);

        for (int t = 0; t < 150; t++) begin
            mode = $urandom_range(0, 3);
            dA = 12'($urandom_range(0, 2047));
            cA = 12'h800 + 12'($urandom_range(0, 2047));
            wd = 8'($urandom);
            we = 1'($urandom_range(0, 1));
            case (mode)
                0:       applyStimulus(1'b1, 1'b0, 1'b0, dA, cA, wd, 2, 0);
                1:       applyStimulus(1'b0, 1'b1, we, dA, cA, wd, 0, 2);
                default: applyStimulus(1'b1, 1'b1, we, dA, cA, wd, 2, 3);
            endcase
        end

        @(negedge clk);
        ioctl_wr = 1'b1; ioctl_index = 8'h7F; ioctl_addr = '0;
        repeat (260) @(negedge clk);
        ioctl_wr = 1'b0;
        @(negedge clk);
        expDrop = (expDrop + 260 > 255) ? 255 : expDrop + 260;
        checkOutput("drop_saturate", drop_count, expDrop);

        // Reset lands in the cycle after a CPU read grant, with a loader write buffered.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
        ioctl_wr = 1'b1; ioctl_index = ROM_INDEX; ioctl_addr = 25'h50; ioctl_dout = ~refMem[12'h050];
        @(negedge clk);
        ioctl_wr = 1'b0;
        reset_n = 1'b0;
        ackSeen = 0;
        repeat (2) begin
            @(negedge clk);
            if (cpu_ack) ackSeen++;
        end
        cpu_req = 1'b0;
        checkOutput("reset_mid_no_ack", ackSeen, 0);
        checkOutput("reset_mid_outputs_zero", |{ioctl_wait, cpu_ack, cpu_rdata, dma_ack, dma_rdata,
                    mem_addr, mem_we, mem_wdata, load_done, drop_count}, 0);
        reset_n = 1'b1;
        expDrop = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset_buffer_discarded", ram[12'h050], refMem[12'h050]);
        checkOutput("reset_drop_count", drop_count, expDrop);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h000, 12'h123, 8'h00, 0, 2);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h050, 12'h3FF, 8'h00, 2, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
